// File: rtl/quad_enc_pkg.sv
// rtl/quad_enc_pkg.sv - count modes, A/B state encodings and the quadrature step table
package quad_enc_pkg;

  localparam logic [1:0] MODE_X1 = 2'd0;
  localparam logic [1:0] MODE_X2 = 2'd1;
  localparam logic [1:0] MODE_X4 = 2'd2;

  // {A, B}
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_10 = 2'b10;
  localparam logic [1:0] AB_11 = 2'b11;

  // Successor of a state when turning right: 11 -> 01 -> 00 -> 10 -> 11.
  function automatic logic [1:0] right_next(input logic [1:0] ab);
    case (ab)
      AB_11:   right_next = AB_01;
      AB_01:   right_next = AB_00;
      AB_00:   right_next = AB_10;
      default: right_next = AB_11;
    endcase
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - tick-sampled debouncer, level moves after LEN equal samples
module debounce_filter #(
  parameter int LEN = 3
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic tick,
  input  logic din,
  output logic dout
);

  logic [LEN-1:0] shift_q, shift_d;
  logic           dout_q, dout_d;

  always_comb begin
    shift_d = shift_q;
    dout_d  = dout_q;
    if (tick) begin
      shift_d = {shift_q[LEN-2:0], din};
      if ((&shift_d) && !dout_q) begin
        dout_d = 1'b1;
      end else if (!(|shift_d) && dout_q) begin
        dout_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shift_q <= '1;
      dout_q  <= 1'b1;
    end else begin
      shift_q <= shift_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/quad_encoder_decoder.sv
// rtl/quad_encoder_decoder.sv - encoder front-end: sync, debounce, x1/x2/x4 decode, position counter
module quad_encoder_decoder
  import quad_enc_pkg::*;
#(
  parameter int CLK_DIV     = 6000,
  parameter int DEB_LEN     = 3,
  parameter int BTN_DEB_LEN = 40,
  parameter int POS_W       = 16,
  parameter bit WRAP        = 1'b1,
  parameter bit DIR_INV     = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             key_a,
  input  logic             key_b,
  input  logic             key_d,
  input  logic [1:0]       cnt_mode,
  input  logic             pos_clr,
  output logic             left_pulse,
  output logic             right_pulse,
  output logic             d_pulse,
  output logic             err_pulse,
  output logic             dir,
  output logic [POS_W-1:0] position
);

  localparam int              TW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [POS_W-1:0] POS_MAX  = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0] POS_MIN  = {1'b1, {(POS_W-1){1'b0}}};

  // Bit order in the synchronisers: {A, B, D}.
  logic [2:0]       sync1_q, sync2_q;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic             a_deb, b_deb, d_deb;
  logic [1:0]       prev_ab_q;
  logic             primed_q, primed_d;
  logic             d_prev_q;
  logic             right_q, left_q, err_q, dpl_q, dir_q;
  logic             right_d, left_d, err_d, dpl_d, dir_d;
  logic [POS_W-1:0] pos_q, pos_d;

  logic [1:0]       ab_cur, ab_diff;
  logic             changed, both, fwd, bwd, allowed;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  debounce_filter #(.LEN(DEB_LEN)) u_deb_a (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .tick(tick), .din(sync2_q[2]), .dout(a_deb)
  );
  debounce_filter #(.LEN(DEB_LEN)) u_deb_b (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .tick(tick), .din(sync2_q[1]), .dout(b_deb)
  );
  debounce_filter #(.LEN(BTN_DEB_LEN)) u_deb_d (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .tick(tick), .din(sync2_q[0]), .dout(d_deb)
  );

  always_comb begin
    ab_cur   = {a_deb, b_deb};
    ab_diff  = ab_cur ^ prev_ab_q;
    changed  = |ab_diff;
    both     = &ab_diff;
    fwd      = (ab_cur == right_next(prev_ab_q));
    bwd      = (prev_ab_q == right_next(ab_cur));
    case (cnt_mode)
      MODE_X1: allowed = ({prev_ab_q, ab_cur} == {AB_11, AB_01}) ||
                         ({prev_ab_q, ab_cur} == {AB_01, AB_11});
      MODE_X2: allowed = (ab_diff == 2'b10);
      default: allowed = changed && !both;
    endcase

    // The first debounced movement after reset only establishes the reference state.
    right_d  = primed_q && allowed && (DIR_INV ? bwd : fwd);
    left_d   = primed_q && allowed && (DIR_INV ? fwd : bwd);
    err_d    = primed_q && both;
    primed_d = primed_q || changed;
    dpl_d    = d_prev_q && !d_deb;

    dir_d = dir_q;
    if (right_d) begin
      dir_d = 1'b1;
    end else if (left_d) begin
      dir_d = 1'b0;
    end

    pos_d = pos_q;
    if (pos_clr) begin
      pos_d = '0;
    end else if (right_d) begin
      pos_d = (!WRAP && pos_q == POS_MAX) ? pos_q : pos_q + 1'b1;
    end else if (left_d) begin
      pos_d = (!WRAP && pos_q == POS_MIN) ? pos_q : pos_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      tick_cnt_q <= '0;
      prev_ab_q  <= AB_11;
      primed_q   <= 1'b0;
      d_prev_q   <= 1'b1;
      right_q    <= 1'b0;
      left_q     <= 1'b0;
      err_q      <= 1'b0;
      dpl_q      <= 1'b0;
      dir_q      <= 1'b0;
      pos_q      <= '0;
    end else begin
      sync1_q    <= {key_a, key_b, key_d};
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
      prev_ab_q  <= ab_cur;
      primed_q   <= primed_d;
      d_prev_q   <= d_deb;
      right_q    <= right_d;
      left_q     <= left_d;
      err_q      <= err_d;
      dpl_q      <= dpl_d;
      dir_q      <= dir_d;
      pos_q      <= pos_d;
    end
  end

  assign right_pulse = right_q;
  assign left_pulse  = left_q;
  assign err_pulse   = err_q;
  assign d_pulse     = dpl_q;
  assign dir         = dir_q;
  assign position    = pos_q;

endmodule
